pwm_capture: RTL
================

# pwm_capture

- Measures the duty cycle of the board's four indicator outputs (LED, RGB_R, RGB_G, RGB_B) and exposes the results through a small register read port.
- It is the reading end of the LED/PWM output path.
- The self-check build instantiates it beside `top`, with its inputs wired to the pin-level LED/RGB nets, so software and benches can confirm the PWM values the core actually drives.
- It handles four independent channels: per-channel edge detection, high-time and period counting, latching, and stuck-level detection.

## Interface

Parameters:
- CNT_W, 16: width of the high-time and period counters and latched results.
- DATA_W, 32: read data width; results are zero-extended into it.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- pwm_in  input  4  channel inputs: bit 0 LED, bit 1 RGB_R, bit 2 RGB_G, bit 3 RGB_B.
- rd_en  input  1  read strobe, single cycle.
- rd_addr  input  4  register address: {ch[1:0], sel[1:0]}.
- rd_data  output  DATA_W  registered read data.
- rd_valid  output  1  one-cycle pulse; rd_data is valid when it is high.

## Operation

Per channel, on the conditioned input `lvl`:
- A rising edge is `lvl`=1 while the previous `lvl`=0.
- **Counters.**
  - period_cnt and high_cnt load 1 on a rising edge.
  - Otherwise period_cnt increments every cycle.
  - high_cnt increments only while `lvl`=1.
  - Both saturate at 2^CNT_W−1.
- **Arming.**
  - The first rising edge after reset or after a stuck event only arms the channel; nothing is latched.
  - On each later rising edge while armed, the block latches high_q ← high_cnt and period_q ← period_cnt, sets valid, clears stuck, and increments cap_cnt (8-bit, wraps 255→0).
- **Stuck detection.**
  - When period_cnt reaches all-ones, the block latches period_q ← all-ones.
  - It latches high_q ← all-ones if `lvl`=1, else 0.
  - It sets valid=1 and stuck=1, disarms the channel, and holds the counters at saturation.
  - The next rising edge re-arms the channel (counters load 1) without latching.
- **A rising edge in the saturation cycle wins:** it is handled as a normal edge, and stuck is not set.
- **Register map**, per channel ch:
  - sel 0: high_q.
  - sel 1: period_q.
  - sel 2: status {29'b0, stuck, lvl, valid}.
  - sel 3: {24'b0, cap_cnt}.
  - Every address decodes. Reads have no side effects.
- **Reset** (rst_n low, any time):
  - Clears all counters, latches, valid, stuck, armed and cap_cnt.
  - Clears rd_data to 0 and rd_valid to 0.
  - Clears synchronizer flops to 0.
  - A capture in progress is discarded.

## Timing

- **Input latency:** with synchronization compiled in, a pin change appears on `lvl` 2 cycles later. The rising edge is detected in the cycle `lvl` first reads 1.
- **Latch timing:** latched values update on the clock edge that ends the rising-edge cycle. A read issued in that same cycle returns the old values.
- **Read latency:** rd_en in cycle t gives rd_data and rd_valid=1 in cycle t+1.
  - Back-to-back reads are allowed, one result per cycle.
  - rd_data holds its last value when rd_valid=0.
- **Worked example:** 3 cycles high, 5 cycles low repeating → period_q=8, high_q=3, latched on the second and every later rising edge.
- **Constant input:**
  - Constant 0 gives valid=1, stuck=1, high_q=0, period_q=2^CNT_W−1.
  - stuck is set 2^CNT_W−1 cycles after the last rising edge. After reset, the count starts with the counters at 0.

## Configuration

- Macro: PWM_CAPTURE_SYNC_EN.
- **Defined:** each pwm_in bit passes through a 2-flop synchronizer (reset to 0) before edge detection. Latency is as in Timing.
- **Undefined:** `lvl` is pwm_in sampled by a single register. Latency is 1 cycle, and the 1-cycle offset applies to every Timing figure. This build is only for inputs already synchronous to clk.

## Structure

- **Package pwm_capture_pkg:**
  - NUM_CH=4.
  - Channel index constants CH_LED/CH_R/CH_G/CH_B.
  - Select constants SEL_HIGH/SEL_PERIOD/SEL_STATUS/SEL_COUNT.
  - Status bit positions.
- **Sub-module pwm_capture_chan**, instantiated 4× via generate, contains:
  - the synchronizer (ifdef),
  - edge detect,
  - counters,
  - the arm/stuck logic,
  - the latched outputs.
- **Top level** contains only the read mux and the rd_data/rd_valid registers.

## Test plan

- Reset with all inputs low, then a read of each of the 16 addresses → rd_data=0, rd_valid one cycle after each rd_en.
- RGB_R at 3 high / 5 low for 4 periods → ch1 high_q=3, period_q=8, valid=1, cap_cnt=3. Other channels have valid=0.
- Four channels with distinct duties: LED 1/4, G 10/20, B 19/20, R 20/20 (R held high after one rising edge) → correct high_q/period_q on ch0/2/3. R reports stuck=1, high_q=0xFFFF after 65535 cycles.
- Reading ch2 SEL_PERIOD in the exact cycle of a latching edge → returns the previous period. A read one cycle later returns the new period.
- rst_n pulsed low mid-period, asynchronously, between clock edges → all outputs 0 immediately. The first post-reset rising edge does not latch, and the second latches correctly.
- 300 captures on LED → cap_cnt=44 (wrap check).

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// Shared constants for the four-channel PWM duty-cycle capture block: channel indices,
// read-port select codes and status-word bit positions.
package pwm_capture_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CAP_W  = 8;

    // Channel order matches the pwm_in bit order.
    localparam logic [1:0] CH_LED = 2'd0;
    localparam logic [1:0] CH_R   = 2'd1;
    localparam logic [1:0] CH_G   = 2'd2;
    localparam logic [1:0] CH_B   = 2'd3;

    typedef enum logic [1:0] {
        SEL_HIGH   = 2'd0,
        SEL_PERIOD = 2'd1,
        SEL_STATUS = 2'd2,
        SEL_COUNT  = 2'd3
    } rd_sel_e;

    localparam int unsigned ST_VALID = 0;
    localparam int unsigned ST_LVL   = 1;
    localparam int unsigned ST_STUCK = 2;
    localparam int unsigned ST_W     = 3;

endpackage

// File: rtl/pwm_capture_chan.sv
// One capture channel: input conditioning, edge detect, high/period counters, arm/stuck tracking
// and result latches. PWM_CAPTURE_SYNC_EN inserts a 2-flop synchronizer ahead of edge detection.
module pwm_capture_chan
    import pwm_capture_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_i,
    output logic [CNT_W-1:0] high_o,
    output logic [CNT_W-1:0] period_o,
    output logic [ST_W-1:0]  status_o,
    output logic [CAP_W-1:0] cap_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_PRE_MAX = CNT_MAX - CNT_ONE;

    logic lvl;

`ifdef PWM_CAPTURE_SYNC_EN
    logic [1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[0], pwm_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign lvl = sync_q[1];
`else
    logic lvl_q, lvl_d;

    always_comb begin
        lvl_d = pwm_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q <= 1'b0;
        end else begin
            lvl_q <= lvl_d;
        end
    end

    assign lvl = lvl_q;
`endif

    logic             prev_q, prev_d;
    logic             armed_q, armed_d;
    logic             valid_q, valid_d;
    logic             stuck_q, stuck_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CAP_W-1:0] cap_cnt_q, cap_cnt_d;
    logic             rise;

    assign rise = lvl & ~prev_q;

    always_comb begin
        prev_d       = lvl;
        armed_d      = armed_q;
        valid_d      = valid_q;
        stuck_d      = stuck_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        period_d     = period_q;
        high_d       = high_q;
        cap_cnt_d    = cap_cnt_q;

        if (rise) begin
            // An edge always wins over a simultaneous saturation; the first edge only arms.
            period_cnt_d = CNT_ONE;
            high_cnt_d   = CNT_ONE;
            armed_d      = 1'b1;
            if (armed_q) begin
                high_d    = high_cnt_q;
                period_d  = period_cnt_q;
                valid_d   = 1'b1;
                stuck_d   = 1'b0;
                cap_cnt_d = cap_cnt_q + CAP_W'(1);
            end
        end else begin
            if (period_cnt_q != CNT_MAX) begin
                period_cnt_d = period_cnt_q + CNT_ONE;
            end
            if (lvl && (high_cnt_q != CNT_MAX)) begin
                high_cnt_d = high_cnt_q + CNT_ONE;
            end
            // Fires once, on the cycle the period counter steps onto all-ones.
            if (period_cnt_q == CNT_PRE_MAX) begin
                period_d = CNT_MAX;
                high_d   = lvl ? CNT_MAX : '0;
                valid_d  = 1'b1;
                stuck_d  = 1'b1;
                armed_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q       <= 1'b0;
            armed_q      <= 1'b0;
            valid_q      <= 1'b0;
            stuck_q      <= 1'b0;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            period_q     <= '0;
            high_q       <= '0;
            cap_cnt_q    <= '0;
        end else begin
            prev_q       <= prev_d;
            armed_q      <= armed_d;
            valid_q      <= valid_d;
            stuck_q      <= stuck_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            period_q     <= period_d;
            high_q       <= high_d;
            cap_cnt_q    <= cap_cnt_d;
        end
    end

    always_comb begin
        status_o           = '0;
        status_o[ST_VALID] = valid_q;
        status_o[ST_LVL]   = lvl;
        status_o[ST_STUCK] = stuck_q;
    end

    assign high_o    = high_q;
    assign period_o  = period_q;
    assign cap_cnt_o = cap_cnt_q;

endmodule

// File: rtl/pwm_capture.sv
// Four-channel PWM duty-cycle capture with a registered read port. Build option
// PWM_CAPTURE_SYNC_EN adds a 2-flop synchronizer per input (see pwm_capture_chan).
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] pwm_in,
    input  logic              rd_en,
    input  logic [3:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    logic [CNT_W-1:0] chan_high   [NUM_CH];
    logic [CNT_W-1:0] chan_period [NUM_CH];
    logic [ST_W-1:0]  chan_status [NUM_CH];
    logic [CAP_W-1:0] chan_cap    [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        pwm_capture_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .pwm_i     (pwm_in[i]),
            .high_o    (chan_high[i]),
            .period_o  (chan_period[i]),
            .status_o  (chan_status[i]),
            .cap_cnt_o (chan_cap[i])
        );
    end

    logic [1:0]        rd_ch;
    rd_sel_e           rd_sel;
    logic [DATA_W-1:0] rd_mux;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    assign rd_ch  = rd_addr[3:2];
    assign rd_sel = rd_sel_e'(rd_addr[1:0]);

    always_comb begin
        rd_mux = '0;
        unique case (rd_sel)
            SEL_HIGH:   rd_mux = DATA_W'(chan_high[rd_ch]);
            SEL_PERIOD: rd_mux = DATA_W'(chan_period[rd_ch]);
            SEL_STATUS: rd_mux = DATA_W'(chan_status[rd_ch]);
            SEL_COUNT:  rd_mux = DATA_W'(chan_cap[rd_ch]);
            default:    rd_mux = '0;
        endcase
    end

    // rd_data holds between reads so software can sample it late.
    always_comb begin
        rd_data_d  = rd_en ? rd_mux : rd_data_q;
        rd_valid_d = rd_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule
